ux607_itcm_arb: RTL and testbench

UX607_ITCM_ARB -- requirements
Module: ux607_itcm_arb

---
 rtl/ux607_itcm_arb_pkg.sv | 21 ++
 rtl/ux607_itcm_pwr_fsm.sv | 70 +++++++
 rtl/ux607_itcm_arb.sv | 125 ++++++++++++
 tb/tb_ux607_itcm_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ux607_itcm_arb_pkg.sv
// Shared ux607 ITCM types: power-FSM state encoding, requester IDs,
// and a width helper for the idle counter.
package ux607_itcm_arb_pkg;

    typedef enum logic [1:0] {
        PWR_RUN   = 2'd0,
        PWR_SLEEP = 2'd1,
        PWR_WAKE  = 2'd2
    } pwr_state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // Bits needed to hold n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ux607_itcm_pwr_fsm.sv
// ITCM light-sleep controller: idle counter plus RUN/SLEEP/WAKE FSM.
// Ports: clk, rst, any_valid_i, grant_i -> state_o, ram_ls_o.
module ux607_itcm_pwr_fsm
    import ux607_itcm_arb_pkg::*;
#(
    parameter int LS_IDLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       any_valid_i,
    input  logic       grant_i,
    output pwr_state_e state_o,
    output logic       ram_ls_o
);

    localparam int CW = cnt_width(LS_IDLE);
    localparam logic [CW-1:0] CNT_LAST =
        (LS_IDLE == 0) ? '0 : CW'(LS_IDLE - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam bit SLEEP_EN = (LS_IDLE != 0);

    pwr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWR_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            PWR_RUN: begin
                if (grant_i) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (SLEEP_EN && (cnt_q == CNT_LAST) && !any_valid_i) begin
                        state_d = PWR_SLEEP;
                    end
                end
            end
            PWR_SLEEP: begin
                if (any_valid_i) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                state_d = PWR_RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = PWR_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign state_o  = state_q;
    assign ram_ls_o = (state_q == PWR_SLEEP);

endmodule

// File: rtl/ux607_itcm_arb.sv
// ITCM arbiter: IFU/LSU onto one single-port RAM with light-sleep control.
// Ports: ifu_req/rsp, lsu_req/rsp, ram_* access and power pins.
// Macro UX607_ITCM_ARB_RR_EN selects round-robin (else LSU fixed priority).
module ux607_itcm_arb
    import ux607_itcm_arb_pkg::*;
#(
    parameter int AW      = 13,
    parameter int DW      = 64,
    parameter int MW      = 8,
    parameter int LS_IDLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_rsp_valid,
    output logic [DW-1:0] ifu_rsp_data,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_req_write,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic [MW-1:0] lsu_req_wem,
    input  logic [DW-1:0] lsu_req_wdata,
    output logic          lsu_rsp_valid,
    output logic [DW-1:0] lsu_rsp_data,
    output logic          ram_cs,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    pwr_state_e pwr_state;
    logic       pwr_ls;
    logic       run;
    logic       gnt_ifu;
    logic       gnt_lsu;
    logic       gnt;

    assign run = !rst && (pwr_state == PWR_RUN);

`ifdef UX607_ITCM_ARB_RR_EN
    req_id_e last_q, last_d;

    // On conflict the requester not granted last wins.
    assign ifu_req_ready = run && (!lsu_req_valid || last_q == REQ_LSU);
    assign lsu_req_ready = run && (!ifu_req_valid || last_q == REQ_IFU);

    always_comb begin
        last_d = last_q;
        if (gnt_lsu) begin
            last_d = REQ_LSU;
        end else if (gnt_ifu) begin
            last_d = REQ_IFU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_IFU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign lsu_req_ready = run;
    assign ifu_req_ready = run && !lsu_req_valid;
`endif

    assign gnt_ifu = ifu_req_valid && ifu_req_ready;
    assign gnt_lsu = lsu_req_valid && lsu_req_ready;
    assign gnt     = gnt_ifu || gnt_lsu;

    ux607_itcm_pwr_fsm #(
        .LS_IDLE (LS_IDLE)
    ) u_pwr (
        .clk         (clk),
        .rst         (rst),
        .any_valid_i (ifu_req_valid || lsu_req_valid),
        .grant_i     (gnt),
        .state_o     (pwr_state),
        .ram_ls_o    (pwr_ls)
    );

    assign ram_cs   = gnt;
    assign ram_addr = gnt_lsu ? lsu_req_addr : ifu_req_addr;
    assign ram_wem  = (gnt_lsu && lsu_req_write) ? lsu_req_wem : '0;
    assign ram_din  = lsu_req_wdata;
    assign ram_ls   = pwr_ls && !rst;
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    logic ifu_rv_q, ifu_rv_d;
    logic lsu_rv_q, lsu_rv_d;
    logic lsu_rd_q, lsu_rd_d;

    always_comb begin
        ifu_rv_d = gnt_ifu;
        lsu_rv_d = gnt_lsu;
        lsu_rd_d = gnt_lsu && !lsu_req_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifu_rv_q <= 1'b0;
            lsu_rv_q <= 1'b0;
            lsu_rd_q <= 1'b0;
        end else begin
            ifu_rv_q <= ifu_rv_d;
            lsu_rv_q <= lsu_rv_d;
            lsu_rd_q <= lsu_rd_d;
        end
    end

    // Gating with rst kills a response to a grant made just before reset.
    assign ifu_rsp_valid = ifu_rv_q && !rst;
    assign lsu_rsp_valid = lsu_rv_q && !rst;
    assign ifu_rsp_data  = ifu_rsp_valid ? ram_dout : '0;
    assign lsu_rsp_data  = (lsu_rsp_valid && lsu_rd_q) ? ram_dout : '0;

endmodule

// File: tb/tb_ux607_itcm_arb.sv
// Randomized self-checking bench for ux607_itcm_arb against a
// cycle-level behavioural model of the arbiter and power FSM.
module tb_ux607_itcm_arb;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int LS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_req_addr = '0;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic          lsu_req_write = 1'b0;
    logic [AW-1:0] lsu_req_addr = '0;
    logic [MW-1:0] lsu_req_wem = '0;
    logic [DW-1:0] lsu_req_wdata = '0;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rsp_data;
    logic          ram_cs;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          ram_ls;
    logic          ram_ds;
    logic          ram_sd;

    logic          z_ifu_ready, z_lsu_ready;
    logic          z_ifu_rv, z_lsu_rv;
    logic [DW-1:0] z_ifu_rd, z_lsu_rd;
    logic          z_cs, z_ls, z_ds, z_sd;
    logic [AW-1:0] z_addr;
    logic [MW-1:0] z_wem;
    logic [DW-1:0] z_din;

    always #5 clk = ~clk;

    ux607_itcm_arb #(
        .AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS)
    ) u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_write(lsu_req_write), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wem(lsu_req_wem), .lsu_req_wdata(lsu_req_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
    );

    ux607_itcm_arb #(
        .AW(AW), .DW(DW), .MW(MW), .LS_IDLE(0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(1'b0), .ifu_req_ready(z_ifu_ready),
        .ifu_req_addr({AW{1'b0}}),
        .ifu_rsp_valid(z_ifu_rv), .ifu_rsp_data(z_ifu_rd),
        .lsu_req_valid(1'b0), .lsu_req_ready(z_lsu_ready),
        .lsu_req_write(1'b0), .lsu_req_addr({AW{1'b0}}),
        .lsu_req_wem({MW{1'b0}}), .lsu_req_wdata({DW{1'b0}}),
        .lsu_rsp_valid(z_lsu_rv), .lsu_rsp_data(z_lsu_rd),
        .ram_cs(z_cs), .ram_addr(z_addr), .ram_wem(z_wem),
        .ram_din(z_din), .ram_dout({DW{1'b1}}),
        .ram_ls(z_ls), .ram_ds(z_ds), .ram_sd(z_sd)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Model: mode 0=run 1=sleep 2=wake; last 0=IFU 1=LSU.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_last = 0;
    bit m_pi   = 0;
    bit m_pl   = 0;
    bit m_plr  = 0;
    bit m_gi   = 0;
    bit m_gl   = 0;

    // Winner of a cycle: 0 none, 1 IFU, 2 LSU.
    function automatic int arb(input bit run, input bit iv, input bit lv);
        if (!run) return 0;
        if (iv && lv) begin
`ifdef UX607_ITCM_ARB_RR_EN
            return (m_last == 1) ? 1 : 2;
`else
            return 2;
`endif
        end
        if (iv) return 1;
        if (lv) return 2;
        return 0;
    endfunction

    task automatic cyc(input bit r, input bit iv, input logic [AW-1:0] ia,
                       input bit lv, input bit lw, input logic [AW-1:0] la,
                       input logic [MW-1:0] lm, input logic [DW-1:0] ld);
        bit run;
        int win;
        @(posedge clk);
        #1;
        rst           = r;
        ifu_req_valid = iv;
        ifu_req_addr  = ia;
        lsu_req_valid = lv;
        lsu_req_write = lw;
        lsu_req_addr  = la;
        lsu_req_wem   = lm;
        lsu_req_wdata = ld;
        ram_dout      = {$urandom, $urandom};
        @(negedge clk);
        run = !r && (m_mode == 0);
        win = arb(run, iv, lv);
        chk("ifu_ready", ifu_req_ready, 64'(arb(run, 1'b1, lv) == 1));
        chk("lsu_ready", lsu_req_ready, 64'(arb(run, iv, 1'b1) == 2));
        chk("ram_cs", ram_cs, 64'(win != 0));
        if (win == 1) chk("ram_addr_i", ram_addr, 64'(ia));
        if (win == 2) chk("ram_addr_l", ram_addr, 64'(la));
        if (win == 2) chk("ram_din", ram_din, ld);
        chk("ram_wem", ram_wem, (win == 2 && lw) ? 64'(lm) : 64'd0);
        chk("ram_ls", ram_ls, 64'(!r && m_mode == 1));
        chk("ds_sd", {ram_ds, ram_sd}, 64'd0);
        chk("ifu_rv", ifu_rsp_valid, 64'(!r && m_pi));
        chk("lsu_rv", lsu_rsp_valid, 64'(!r && m_pl));
        if (r || m_pi)
            chk("ifu_rd", ifu_rsp_data, (!r && m_pi) ? ram_dout : 64'd0);
        if (r || m_pl)
            chk("lsu_rd", lsu_rsp_data,
                (!r && m_pl && m_plr) ? ram_dout : 64'd0);
        chk("d0_ls_cs", {z_ls, z_cs, z_ds, z_sd}, 64'd0);
        chk("d0_rdy", {z_ifu_ready, z_lsu_ready}, r ? 64'd0 : 64'd3);
        chk("d0_rsp", {z_ifu_rv, z_lsu_rv, z_ifu_rd, z_lsu_rd}, 64'd0);
        m_gi = (win == 1);
        m_gl = (win == 2);
        if (r) begin
            m_mode = 0; m_cnt = 0; m_last = 0;
            m_pi = 0; m_pl = 0; m_plr = 0;
        end else begin
            m_pi  = (win == 1);
            m_pl  = (win == 2);
            m_plr = (win == 2) && !lw;
            if (win != 0) m_last = (win == 2) ? 1 : 0;
            case (m_mode)
                0: begin
                    if (win != 0) m_cnt = 0;
                    else if (m_cnt == LS - 1 && !(iv || lv)) m_mode = 1;
                    else if (m_cnt < 1000) m_cnt++;
                end
                1: if (iv || lv) m_mode = 2;
                default: begin m_mode = 0; m_cnt = 0; end
            endcase
        end
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, '0, 0, 0, '0, '0, '0);
    endtask

    bit            h_iv = 0, h_lv = 0, h_lw = 0;
    logic [AW-1:0] h_ia = '0, h_la = '0;
    logic [MW-1:0] h_lm = '0;
    logic [DW-1:0] h_ld = '0;
    logic [DW-1:0] d_snap;
    bit            e_l;

    initial begin
        idle(1);
        idle(1);
        chk("rst_cs", ram_cs, 64'd0);
        chk("rst_rdy", {ifu_req_ready, lsu_req_ready}, 64'd0);

        // Both requesters valid for four cycles straight out of reset.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 13'h100, 1, 0, 13'h200, '0, '0);
`ifdef UX607_ITCM_ARB_RR_EN
            e_l = (k % 2 == 0);
`else
            e_l = 1'b1;
`endif
            chk("conf_lsu_rdy", lsu_req_ready, 64'(e_l));
            chk("conf_ifu_rdy", ifu_req_ready, 64'(!e_l));
        end
        idle(1);

        cyc(0, 1, 13'h010, 0, 0, '0, '0, '0);
        chk("fetch_cs", ram_cs, 64'd1);
        chk("fetch_addr", ram_addr, 64'h010);
        idle(0);
        chk("fetch_rv", ifu_rsp_valid, 64'd1);
        d_snap = ram_dout;
        chk("fetch_rd", ifu_rsp_data, d_snap);

        cyc(0, 0, '0, 1, 1, 13'h020, 8'h0F, 64'h1122334455667788);
        chk("st_wem", ram_wem, 64'h0F);
        chk("st_din", ram_din, 64'h1122334455667788);
        idle(0);
        chk("st_rv", lsu_rsp_valid, 64'd1);
        chk("st_rd", lsu_rsp_data, 64'd0);

        for (int k = 0; k < 15; k++) idle(0);
        chk("pre_sleep_ls", ram_ls, 64'd0);
        idle(0);
        chk("sleep_ls", ram_ls, 64'd1);
        cyc(0, 1, 13'h033, 0, 0, '0, '0, '0);
        chk("sleep_rdy", ifu_req_ready, 64'd0);
        cyc(0, 1, 13'h033, 0, 0, '0, '0, '0);
        chk("wake_ls", ram_ls, 64'd0);
        chk("wake_rdy", ifu_req_ready, 64'd0);
        cyc(0, 1, 13'h033, 0, 0, '0, '0, '0);
        chk("wake_gnt", ram_cs, 64'd1);

        cyc(0, 1, 13'h044, 0, 0, '0, '0, '0);
        idle(1);
        chk("rst_drop_rv", ifu_rsp_valid, 64'd0);
        idle(0);
        chk("no_stale_rv", ifu_rsp_valid, 64'd0);
        chk("post_rst_rdy", ifu_req_ready, 64'd1);

        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            bit r;
            quiet = ((i % 300) >= 260);
            if (!(h_iv && !m_gi)) begin
                h_iv = !quiet && ($urandom_range(0, 1) == 1);
                h_ia = AW'($urandom);
            end
            if (!(h_lv && !m_gl)) begin
                h_lv = !quiet && ($urandom_range(0, 2) == 0);
                h_lw = $urandom_range(0, 1) == 1;
                h_la = AW'($urandom);
                h_lm = MW'($urandom);
                h_ld = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 249) == 0);
            cyc(r, h_iv, h_ia, h_lv, h_lw, h_la, h_lm, h_ld);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
